pll_frac_ssc_ctrl: RTL and testbench

PLL_FRAC_SSC_CTRL -- requirements
Module: pll_frac_ssc_ctrl

---
 rtl/pll_frac_ssc_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pll_frac_ssc_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_frac_ssc_ctrl.sv
// Fractional-N feedback-divider controller: MASH-1/1-1/1-1-1 sigma-delta with an optional
// triangular spread-spectrum frequency offset, included only when PLL_SSC_EN is defined.
module pll_frac_ssc_ctrl #(
  parameter int RATIO_W   = 10,
  parameter int FRAC_W    = 24,
  parameter int SSC_CNT_W = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [RATIO_W-1:0]   ratio_i,
  input  logic [FRAC_W-1:0]    fraction_i,
  input  logic [1:0]           mash_order_i,
  input  logic                 ssc_en_i,
  input  logic [SSC_CNT_W-1:0] ssc_cyc_to_peak_m1_i,
  input  logic [FRAC_W-1:0]    ssc_frac_step_i,
  output logic [RATIO_W:0]     div_o,
  output logic                 div_valid_o,
  output logic                 ssc_active_o,
  output logic                 ssc_dir_o
);
  localparam int FW_W = RATIO_W + FRAC_W;
  localparam int DS_W = RATIO_W + 2;

  typedef enum logic [1:0] {IDLE, RUN_DN, RUN_UP} state_t;
  state_t state_reg, state_next;

  logic [RATIO_W-1:0] ratio_reg;
  logic [FRAC_W-1:0]  fraction_reg;
  logic [1:0]         mash_reg;
  logic [FRAC_W-1:0]  acc1_reg, acc2_reg, acc3_reg;
  logic               c2_d_reg, c3_d_reg, c3_dd_reg;
  logic [RATIO_W:0]   div_reg;
  logic               valid_reg;

  logic [FW_W-1:0]    off;
  logic               ssc_turn;

`ifdef PLL_SSC_EN
  logic                 ssc_en_reg;
  logic [SSC_CNT_W-1:0] cyc_m1_reg, cnt_reg;
  logic [FRAC_W-1:0]    step_reg;
  logic [FW_W-1:0]      off_reg, off_next, step_ext;
  logic [FW_W:0]        off_add;

  assign off      = off_reg;
  assign ssc_turn = (cnt_reg == cyc_m1_reg);
  assign step_ext = {{RATIO_W{1'b0}}, step_reg};

  // Offset saturates high while ramping down and clamps at zero while ramping up.
  always_comb begin
    off_add  = {1'b0, off_reg} + {1'b0, step_ext};
    off_next = off_reg;
    if (ssc_en_reg) begin
      if (state_reg == RUN_DN)
        off_next = off_add[FW_W] ? '1 : off_add[FW_W-1:0];
      else
        off_next = (off_reg >= step_ext) ? off_reg - step_ext : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ssc_en_reg <= 1'b0;
      cyc_m1_reg <= '0;
      step_reg   <= '0;
      off_reg    <= '0;
      cnt_reg    <= '0;
    end else if (state_reg == IDLE) begin
      off_reg <= '0;
      cnt_reg <= '0;
      if (en_i) begin
        ssc_en_reg <= ssc_en_i;
        cyc_m1_reg <= ssc_cyc_to_peak_m1_i;
        step_reg   <= ssc_frac_step_i;
      end
    end else if (!en_i) begin
      off_reg <= '0;
      cnt_reg <= '0;
    end else begin
      off_reg <= off_next;
      cnt_reg <= ssc_turn ? '0 : cnt_reg + SSC_CNT_W'(1);
    end
  end

  assign ssc_active_o = ssc_en_reg && (state_reg != IDLE);
  assign ssc_dir_o    = (state_reg == RUN_UP);
`else
  logic unused_ssc;
  assign unused_ssc   = ^{ssc_en_i, ssc_cyc_to_peak_m1_i, ssc_frac_step_i};
  assign off          = '0;
  assign ssc_turn     = 1'b0;
  assign ssc_active_o = 1'b0;
  assign ssc_dir_o    = 1'b0;
`endif

  logic [FW_W-1:0]   base, fw;
  logic [FRAC_W:0]   sum1, sum2, sum3;
  logic [3:0]        corr;
  logic [DS_W-1:0]   div_sum;
  logic [RATIO_W:0]  div_next;

  always_comb begin
    base = {ratio_reg, fraction_reg};
    fw   = (base >= off) ? base - off : '0;
    sum1 = {1'b0, acc1_reg} + {1'b0, fw[FRAC_W-1:0]};
    sum2 = {1'b0, acc2_reg} + {1'b0, sum1[FRAC_W-1:0]};
    sum3 = {1'b0, acc3_reg} + {1'b0, sum2[FRAC_W-1:0]};
    // 4-bit two's-complement is enough for the -3..+4 noise-shaped correction.
    case (mash_reg)
      2'd1:    corr = {3'b0, sum1[FRAC_W]};
      2'd2:    corr = {3'b0, sum1[FRAC_W]} + {3'b0, sum2[FRAC_W]} - {3'b0, c2_d_reg};
      2'd3:    corr = {3'b0, sum1[FRAC_W]} + {3'b0, sum2[FRAC_W]} - {3'b0, c2_d_reg}
                    + {3'b0, sum3[FRAC_W]} - {2'b0, c3_d_reg, 1'b0} + {3'b0, c3_dd_reg};
      default: corr = 4'd0;
    endcase
    div_sum = {2'b00, fw[FW_W-1:FRAC_W]} + {{(DS_W-4){corr[3]}}, corr};
    // A non-negative sum always fits RATIO_W+1 bits, so only the low clamp is needed.
    if (div_sum[DS_W-1] || (div_sum == '0))
      div_next = {{RATIO_W{1'b0}}, 1'b1};
    else
      div_next = div_sum[RATIO_W:0];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en_i) state_next = RUN_DN;
      RUN_DN:  if (!en_i) state_next = IDLE; else if (ssc_turn) state_next = RUN_UP;
      RUN_UP:  if (!en_i) state_next = IDLE; else if (ssc_turn) state_next = RUN_DN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      ratio_reg    <= '0;
      fraction_reg <= '0;
      mash_reg     <= '0;
      acc1_reg     <= '0;
      acc2_reg     <= '0;
      acc3_reg     <= '0;
      c2_d_reg     <= 1'b0;
      c3_d_reg     <= 1'b0;
      c3_dd_reg    <= 1'b0;
      div_reg      <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) || !en_i) begin
        acc1_reg  <= '0;
        acc2_reg  <= '0;
        acc3_reg  <= '0;
        c2_d_reg  <= 1'b0;
        c3_d_reg  <= 1'b0;
        c3_dd_reg <= 1'b0;
        div_reg   <= '0;
        valid_reg <= 1'b0;
        if ((state_reg == IDLE) && en_i) begin
          ratio_reg    <= ratio_i;
          fraction_reg <= fraction_i;
          mash_reg     <= mash_order_i;
        end
      end else begin
        acc1_reg  <= sum1[FRAC_W-1:0];
        acc2_reg  <= sum2[FRAC_W-1:0];
        acc3_reg  <= sum3[FRAC_W-1:0];
        c2_d_reg  <= sum2[FRAC_W];
        c3_d_reg  <= sum3[FRAC_W];
        c3_dd_reg <= c3_d_reg;
        div_reg   <= div_next;
        valid_reg <= 1'b1;
      end
    end
  end

  assign div_o       = div_reg;
  assign div_valid_o = valid_reg;
endmodule

// File: tb/tb_pll_frac_ssc_ctrl.sv
// Scoreboard bench for pll_frac_ssc_ctrl: an arithmetic reference model pushes the expected
// divide value per run cycle, a negedge monitor pops and compares whenever div_valid_o is high.
module tb_pll_frac_ssc_ctrl;
  localparam int RATIO_W   = 10;
  localparam int FRAC_W    = 24;
  localparam int SSC_CNT_W = 9;
  localparam longint FMASK   = (64'sd1 << FRAC_W) - 1;
  localparam longint OFF_MAX = (64'sd1 << (FRAC_W + RATIO_W)) - 1;
  localparam longint DIV_MAX = (64'sd1 << (RATIO_W + 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rst_ni, en_i;
  logic [RATIO_W-1:0]   ratio_i;
  logic [FRAC_W-1:0]    fraction_i;
  logic [1:0]           mash_order_i;
  logic                 ssc_en_i;
  logic [SSC_CNT_W-1:0] ssc_cyc_to_peak_m1_i;
  logic [FRAC_W-1:0]    ssc_frac_step_i;
  logic [RATIO_W:0]     div_o;
  logic                 div_valid_o, ssc_active_o, ssc_dir_o;

  pll_frac_ssc_ctrl #(.RATIO_W(RATIO_W), .FRAC_W(FRAC_W), .SSC_CNT_W(SSC_CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .ratio_i(ratio_i), .fraction_i(fraction_i),
    .mash_order_i(mash_order_i), .ssc_en_i(ssc_en_i), .ssc_cyc_to_peak_m1_i(ssc_cyc_to_peak_m1_i),
    .ssc_frac_step_i(ssc_frac_step_i), .div_o(div_o), .div_valid_o(div_valid_o),
    .ssc_active_o(ssc_active_o), .ssc_dir_o(ssc_dir_o)
  );

  always #5 clk = ~clk;

  typedef struct { int div; bit dir; bit act; } exp_t;
  exp_t sb_q[$];

  int     n_checks = 0;
  int     n_fail   = 0;
  longint obs_sum;
  int     obs_min, obs_max;

  // Model state: the captured configuration plus the sigma-delta and SSC history.
  longint m_ratio, m_frac, m_step, m_off, m_a1, m_a2, m_a3;
  int     m_mash, m_m1, m_cnt, m_c2d, m_c3d, m_c3dd;
  bit     m_ssc, m_up;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected within [%0d, %0d]", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_ni === 1'b1 && div_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_valid: got div_o=%0d with valid, expected no valid output", div_o);
      end else begin
        e = sb_q.pop_front();
        check("div_o", div_o, e.div);
        check("ssc_dir_o", ssc_dir_o, e.dir);
        check("ssc_active_o", ssc_active_o, e.act);
        obs_sum += longint'(div_o);
        if (int'(div_o) < obs_min) obs_min = int'(div_o);
        if (int'(div_o) > obs_max) obs_max = int'(div_o);
      end
    end
  end

  task automatic set_cfg(input int ratio, input longint frac, input int mash,
                         input bit ssc, input int m1, input longint step);
    ratio_i              = RATIO_W'(ratio);
    fraction_i           = FRAC_W'(frac);
    mash_order_i         = 2'(mash);
    ssc_en_i             = ssc;
    ssc_cyc_to_peak_m1_i = SSC_CNT_W'(m1);
    ssc_frac_step_i      = FRAC_W'(step);
    m_ratio = ratio; m_frac = frac; m_mash = mash;
    m_ssc = ssc; m_m1 = m1; m_step = step;
  endtask

  task automatic scramble();
    ratio_i              = RATIO_W'($urandom);
    fraction_i           = FRAC_W'($urandom);
    mash_order_i         = 2'($urandom);
    ssc_en_i             = 1'($urandom);
    ssc_cyc_to_peak_m1_i = SSC_CNT_W'($urandom);
    ssc_frac_step_i      = FRAC_W'($urandom);
  endtask

  // One reference cycle: divide value from the current offset, then advance the SSC ramp.
  task automatic model_step(output exp_t e);
    longint base, fw, s1, s2, s3, d;
    int c1, c2, c3, corr;
    base = (m_ratio << FRAC_W) + m_frac;
    fw   = (base >= m_off) ? base - m_off : 0;
    s1 = m_a1 + (fw & FMASK); c1 = int'(s1 >> FRAC_W); m_a1 = s1 & FMASK;
    s2 = m_a2 + m_a1;         c2 = int'(s2 >> FRAC_W); m_a2 = s2 & FMASK;
    s3 = m_a3 + m_a2;         c3 = int'(s3 >> FRAC_W); m_a3 = s3 & FMASK;
    case (m_mash)
      1:       corr = c1;
      2:       corr = c1 + c2 - m_c2d;
      3:       corr = c1 + c2 - m_c2d + c3 - 2 * m_c3d + m_c3dd;
      default: corr = 0;
    endcase
    m_c3dd = m_c3d; m_c3d = c3; m_c2d = c2;
    d = (fw >> FRAC_W) + corr;
    if (d < 1) d = 1;
    if (d > DIV_MAX) d = DIV_MAX;
    e.div = int'(d);
`ifdef PLL_SSC_EN
    if (m_ssc) begin
      if (!m_up) m_off = (m_off + m_step > OFF_MAX) ? OFF_MAX : m_off + m_step;
      else       m_off = (m_off > m_step) ? m_off - m_step : 0;
    end
    if (m_cnt == m_m1) begin m_cnt = 0; m_up = !m_up; end
    else m_cnt++;
    e.dir = m_up;
    e.act = m_ssc;
`else
    e.dir = 1'b0;
    e.act = 1'b0;
`endif
  endtask

  // Entered on a negedge with the DUT idle; n cycles of output, then stop.
  // rst_at > 0 replaces cycle rst_at with an asynchronous reset pulse between edges.
  task automatic run(input int n, input int rst_at, input bit scr);
    exp_t e;
    obs_sum = 0; obs_min = 1 << 30; obs_max = -1;
    m_off = 0; m_a1 = 0; m_a2 = 0; m_a3 = 0; m_cnt = 0; m_up = 1'b0;
    m_c2d = 0; m_c3d = 0; m_c3dd = 0;
    en_i = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) check("first_cycle_not_valid", div_valid_o, 0);
      if (k == rst_at) begin
        #2 rst_ni = 1'b0;
        #1;
        check("rst_div_o", div_o, 0);
        check("rst_div_valid_o", div_valid_o, 0);
        check("rst_ssc_active_o", ssc_active_o, 0);
        check("rst_ssc_dir_o", ssc_dir_o, 0);
        #1 rst_ni = 1'b1;
        en_i = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("post_rst_idle_valid", div_valid_o, 0);
        return;
      end
      model_step(e);
      sb_q.push_back(e);
      if (scr && $urandom_range(0, 2) == 0) scramble();
    end
    @(negedge clk);
    en_i = 1'b0;
    @(negedge clk);
    check("valid_after_stop", div_valid_o, 0);
    check("div_after_stop", div_o, 0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    int ratio, mash, m1, n, rst_at;
    longint frac, step;
    bit ssc;
    rst_ni = 1'b0;
    en_i   = 1'b0;
    set_cfg(0, 0, 0, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset_div_o", div_o, 0);
    check("reset_div_valid_o", div_valid_o, 0);
    check("reset_ssc_active_o", ssc_active_o, 0);
    check("reset_ssc_dir_o", ssc_dir_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("idle_no_valid", div_valid_o, 0);

    set_cfg(20, 0, 2, 1'b0, 0, 0);
    run(20, 0, 1'b1);
    check_range("int_only_min", obs_min, 20, 20);
    check_range("int_only_max", obs_max, 20, 20);

    set_cfg(20, 64'h800000, 1, 1'b0, 0, 0);
    run(64, 0, 1'b0);
    check("mash1_sum64", obs_sum, 1312);

    set_cfg(20, 64'h400000, 3, 1'b0, 0, 0);
    run(4096, 0, 1'b0);
    check_range("mash3_sum4096", obs_sum, 82941, 82947);
    check_range("mash3_min", obs_min, 17, 24);
    check_range("mash3_max", obs_max, 17, 24);

    set_cfg(20, 0, 1, 1'b1, 3, 64'h010000);
    run(8, 0, 1'b0);
`ifdef PLL_SSC_EN
    check_range("ssc_sum_one_period", obs_sum, 0, 159);
`endif

    set_cfg(20, 0, 1, 1'b1, 3, 64'h010000);
    run(20, 6, 1'b0);

    set_cfg(20, 64'h123456, 2, 1'b1, 2, 64'h020000);
    run(11, 0, 1'b1);
    repeat (3) @(negedge clk);
    set_cfg(30, 0, 1, 1'b1, 2, 64'h020000);
    run(10, 0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 4))
        0:       ratio = 0;
        1:       ratio = 1;
        2:       ratio = (1 << RATIO_W) - 1;
        default: ratio = int'($urandom_range(2, (1 << RATIO_W) - 2));
      endcase
      case ($urandom_range(0, 3))
        0:       frac = 0;
        1:       frac = FMASK;
        default: frac = longint'($urandom_range(0, 32'hFFFFFF));
      endcase
      mash = int'($urandom_range(0, 3));
      ssc  = 1'($urandom_range(0, 1));
      m1   = int'($urandom_range(0, 7));
      step = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 32'hFFFFFF))
                                         : longint'($urandom_range(0, 32'h03FFFF));
      n      = int'($urandom_range(5, 60));
      rst_at = (r % 7 == 3) ? int'($urandom_range(2, n)) : 0;
      set_cfg(ratio, frac, mash, ssc, m1, step);
      run(n, rst_at, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
